// File: rtl/uart_led_pkg.sv
// Shared constants, state encodings and helpers for the UART LED frame receiver.
package uart_led_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CMD_RAW   = 8'h01;
  localparam logic [7:0] CMD_LEVEL = 8'h02;

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAIT} rx_state_e;
  typedef enum logic [1:0] {S_SYNC, S_CMD, S_DATA, S_CHK} parse_state_e;

  // Thermometer bar of min(level, 8) lit LEDs, starting from bit 0.
  function automatic logic [7:0] level_to_bar(input logic [7:0] level);
    logic [7:0] bar;
    for (int i = 0; i < 8; i++) bar[i] = (level > 8'(i));
    return bar;
  endfunction

endpackage

// File: rtl/uart_led_frame_rx_core.sv
// 8N1 UART receiver: RXD synchroniser, 16x oversample tick generator and bit FSM.
module uart_rx_core
  import uart_led_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rxd_i,
  output logic       tick_o,
  output logic [7:0] byte_o,
  output logic       valid_o,
  output logic       framing_err_o
);

  localparam int OVS_DIV = CLK_HZ / (BAUD * 16);
  localparam int TW      = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;

  logic [TW-1:0] div_q;
  logic          tick;
  logic          sync1_q, sync2_q, rxd;
  rx_state_e     state_q, state_d;
  logic [3:0]    os_q, os_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    byte_q;
  logic          valid_q, valid_d, ferr_q, ferr_d;

  assign tick = (div_q == TW'(OVS_DIV - 1));
  assign rxd  = sync2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q   <= '0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= R_IDLE;
      os_q    <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      div_q   <= tick ? '0 : div_q + 1'b1;
      sync1_q <= rxd_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      if (valid_d) byte_q <= shift_q;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_ff @(posedge clk_i) shift_q <= shift_d;

  // Bit timing: mid start bit after 8 ticks, then every 16 ticks thereafter.
  always_comb begin
    state_d = state_q;
    os_d    = os_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    if (tick) begin
      unique case (state_q)
        R_IDLE: if (!rxd) begin
          state_d = R_START;
          os_d    = '0;
        end
        R_START: if (os_q == 4'd7) begin
          os_d    = '0;
          bit_d   = '0;
          state_d = rxd ? R_IDLE : R_DATA;
        end else os_d = os_q + 4'd1;
        R_DATA: if (os_q == 4'd15) begin
          os_d    = '0;
          shift_d = {rxd, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = R_STOP;
        end else os_d = os_q + 4'd1;
        R_STOP: if (os_q == 4'd15) begin
          os_d    = '0;
          state_d = rxd ? R_IDLE : R_WAIT;
        end else os_d = os_q + 4'd1;
        R_WAIT: if (rxd) state_d = R_IDLE;
        default: state_d = R_IDLE;
      endcase
    end
  end

  always_comb begin
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    if (tick && state_q == R_STOP && os_q == 4'd15) begin
      valid_d = rxd;
      ferr_d  = !rxd;
    end
  end

  assign tick_o        = tick;
  assign byte_o        = byte_q;
  assign valid_o       = valid_q;
  assign framing_err_o = ferr_q;

endmodule

// File: rtl/uart_led_frame_rx.sv
// UART command-frame parser (A5 CMD DATA CHK) driving the LED bank, with inter-byte timeout.
module uart_led_frame_rx
  import uart_led_pkg::*;
#(
  parameter int CLK_HZ       = 50000000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       rs232_rxd,
  output logic [7:0] led_export,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_framing_err,
  output logic       frame_ok,
  output logic       frame_err
);

  localparam int TO_TICKS = TIMEOUT_BITS * 16;
  localparam int GW       = $clog2(TO_TICKS + 1);

  logic         tick;
  parse_state_e pstate_q, pstate_d;
  logic [7:0]   cmd_q, cmd_d, data_q, data_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]   led_q, led_d;
  logic         ok_q, ok_d, ferr_q, ferr_d;
  logic         timeout, chk_ok, cmd_known, in_chk, accept;

  uart_rx_core #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_core (
    .clk_i        (clk_clk),
    .rst_ni       (reset_reset_n),
    .rxd_i        (rs232_rxd),
    .tick_o       (tick),
    .byte_o       (rx_byte),
    .valid_o      (rx_valid),
    .framing_err_o(rx_framing_err)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      pstate_q <= S_SYNC;
      cmd_q    <= '0;
      data_q   <= '0;
      gap_q    <= '0;
      led_q    <= '0;
      ok_q     <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      pstate_q <= pstate_d;
      cmd_q    <= cmd_d;
      data_q   <= data_d;
      gap_q    <= gap_d;
      led_q    <= led_d;
      ok_q     <= ok_d;
      ferr_q   <= ferr_d;
    end
  end

  assign timeout = (pstate_q != S_SYNC) && (gap_q == GW'(TO_TICKS));

  // A received byte takes priority over a coincident timeout or resync.
  always_comb begin
    pstate_d = pstate_q;
    cmd_d    = cmd_q;
    data_d   = data_q;
    if (rx_valid) begin
      unique case (pstate_q)
        S_SYNC: if (rx_byte == SYNC_BYTE) pstate_d = S_CMD;
        S_CMD: begin
          cmd_d    = rx_byte;
          pstate_d = S_DATA;
        end
        S_DATA: begin
          data_d   = rx_byte;
          pstate_d = S_CHK;
        end
        default: pstate_d = S_SYNC;
      endcase
    end else if (rx_framing_err || timeout) begin
      pstate_d = S_SYNC;
    end
    if (rx_valid || pstate_q == S_SYNC) gap_d = '0;
    else if (tick && !timeout)          gap_d = gap_q + 1'b1;
    else                                gap_d = gap_q;
  end

  always_comb begin
    chk_ok    = (rx_byte == (cmd_q ^ data_q));
    cmd_known = (cmd_q == CMD_RAW) || (cmd_q == CMD_LEVEL);
    in_chk    = rx_valid && (pstate_q == S_CHK);
    accept    = in_chk && chk_ok && cmd_known;
    ok_d      = accept;
    ferr_d    = (in_chk && !accept) || (!rx_valid && timeout);
    led_d     = led_q;
    if (accept) led_d = (cmd_q == CMD_RAW) ? data_q : level_to_bar(data_q);
  end

  // Framing errors mid-frame are flagged on the same cycle the receiver reports them.
  assign frame_err  = ferr_q || (rx_framing_err && pstate_q != S_SYNC);
  assign frame_ok   = ok_q;
  assign led_export = led_q;

endmodule

// File: tb/tb_uart_led_frame_rx.sv
// Directed bench for uart_led_frame_rx: frames, errors, timeout, glitch and mid-byte reset.
module tb_uart_led_frame_rx;
  import uart_led_pkg::*;

  // 5.5296 MHz / (115200*16) = 3 clocks per tick, 48 clocks per bit.
  localparam int CLK_HZ   = 5529600;
  localparam int BAUD     = 115200;
  localparam int BIT_CLKS = 48;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd;
  logic [7:0] led_export, rx_byte;
  logic       rx_valid, rx_framing_err, frame_ok, frame_err;

  always #5 clk = ~clk;

  uart_led_frame_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .TIMEOUT_BITS(32)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .rs232_rxd     (rxd),
    .led_export    (led_export),
    .rx_byte       (rx_byte),
    .rx_valid      (rx_valid),
    .rx_framing_err(rx_framing_err),
    .frame_ok      (frame_ok),
    .frame_err     (frame_err)
  );

  int checks = 0, errors = 0;
  int cyc = 0, n_valid = 0, n_ok = 0, n_ferr = 0, n_rxerr = 0;
  int last_valid_cyc = 0, last_ferr_cyc = 0, last_rxerr_cyc = 0;
  logic [7:0] led_at_ok = 8'h00;
  int v0, o0, e0, r0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rx_valid) begin
      n_valid <= n_valid + 1;
      last_valid_cyc <= cyc;
    end
    if (frame_ok) begin
      n_ok <= n_ok + 1;
      led_at_ok <= led_export;
    end
    if (frame_err) begin
      n_ferr <= n_ferr + 1;
      last_ferr_cyc <= cyc;
    end
    if (rx_framing_err) begin
      n_rxerr <= n_rxerr + 1;
      last_rxerr_cyc <= cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_clks(BIT_CLKS);
    end
    rxd = stop;
    wait_clks(BIT_CLKS);
    rxd = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] s, input logic [7:0] c,
                            input logic [7:0] d, input logic [7:0] k);
    send_byte(s, 1'b1);
    send_byte(c, 1'b1);
    send_byte(d, 1'b1);
    send_byte(k, 1'b1);
  endtask

  task automatic snap();
    v0 = n_valid;
    o0 = n_ok;
    e0 = n_ferr;
    r0 = n_rxerr;
  endtask

  initial begin
    rst_n = 1'b0;
    rxd   = 1'b1;
    wait_clks(5);
    check("rst_led", 32'(led_export), 32'h00);
    check("rst_rx_byte", 32'(rx_byte), 32'h00);
    check("rst_pulses", 32'({rx_valid, rx_framing_err, frame_ok, frame_err}), 32'h0);
    check("rst_core_state", 32'(dut.u_core.state_q), 32'(R_IDLE));
    check("rst_parser_state", 32'(dut.pstate_q), 32'(S_SYNC));
    rst_n = 1'b1;
    wait_clks(10);

    snap();
    send_frame(8'hA5, 8'h01, 8'h3C, 8'h3D);
    wait_clks(BIT_CLKS);
    check("raw_valid_count", 32'(n_valid - v0), 32'd4);
    check("raw_ok_count", 32'(n_ok - o0), 32'd1);
    check("raw_err_count", 32'(n_ferr - e0), 32'd0);
    check("raw_led", 32'(led_export), 32'h3C);
    check("raw_last_byte", 32'(rx_byte), 32'h3D);

    send_frame(8'hA5, 8'h02, 8'h05, 8'h07);
    wait_clks(BIT_CLKS);
    check("level5_led", 32'(led_export), 32'h1F);
    send_frame(8'hA5, 8'h02, 8'h20, 8'h22);
    wait_clks(BIT_CLKS);
    check("level32_led", 32'(led_export), 32'hFF);
    send_frame(8'hA5, 8'h02, 8'h00, 8'h02);
    wait_clks(BIT_CLKS);
    check("level0_led", 32'(led_export), 32'h00);
    send_frame(8'hA5, 8'h02, 8'h08, 8'h0A);
    wait_clks(BIT_CLKS);
    check("level8_led", 32'(led_export), 32'hFF);

    snap();
    send_frame(8'hA5, 8'h01, 8'h3C, 8'h00);
    wait_clks(BIT_CLKS);
    check("badchk_err", 32'(n_ferr - e0), 32'd1);
    check("badchk_no_ok", 32'(n_ok - o0), 32'd0);
    check("badchk_led_kept", 32'(led_export), 32'hFF);

    snap();
    send_frame(8'hA5, 8'h03, 8'h11, 8'h12);
    wait_clks(BIT_CLKS);
    check("badcmd_err", 32'(n_ferr - e0), 32'd1);
    check("badcmd_led_kept", 32'(led_export), 32'hFF);
    send_frame(8'hA5, 8'h01, 8'h5A, 8'h5B);
    wait_clks(BIT_CLKS);
    check("after_bad_led", 32'(led_export), 32'h5A);

    snap();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h55, 1'b0);
    wait_clks(2 * BIT_CLKS);
    check("framing_rx_valid", 32'(n_valid - v0), 32'd1);
    check("framing_rxerr", 32'(n_rxerr - r0), 32'd1);
    check("framing_frame_err", 32'(n_ferr - e0), 32'd1);
    check("framing_same_cycle", 32'(last_ferr_cyc), 32'(last_rxerr_cyc));
    check("framing_led_kept", 32'(led_export), 32'h5A);
    send_frame(8'hA5, 8'h01, 8'h81, 8'h80);
    wait_clks(BIT_CLKS);
    check("resync_led", 32'(led_export), 32'h81);
    check("ok_with_led", 32'(led_at_ok), 32'h81);

    snap();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    wait_clks(40 * BIT_CLKS);
    check("timeout_err", 32'(n_ferr - e0), 32'd1);
    check("timeout_window", 32'((last_ferr_cyc - last_valid_cyc) >= 1530 &&
                                (last_ferr_cyc - last_valid_cyc) <= 1542), 32'd1);
    check("timeout_led_kept", 32'(led_export), 32'h81);
    check("timeout_parser_sync", 32'(dut.pstate_q), 32'(S_SYNC));
    send_frame(8'hA5, 8'h02, 8'h03, 8'h01);
    wait_clks(BIT_CLKS);
    check("after_timeout_led", 32'(led_export), 32'h07);

    snap();
    rxd = 1'b0;
    wait_clks(14);
    rxd = 1'b1;
    wait_clks(3 * BIT_CLKS);
    check("glitch_no_valid", 32'(n_valid - v0), 32'd0);
    check("glitch_no_errs", 32'((n_ferr - e0) + (n_rxerr - r0)), 32'd0);
    check("glitch_core_idle", 32'(dut.u_core.state_q), 32'(R_IDLE));

    rxd = 1'b0;
    wait_clks(BIT_CLKS);
    rxd = 1'b1;
    wait_clks(100);
    rst_n = 1'b0;
    wait_clks(2);
    check("midbyte_rst_led", 32'(led_export), 32'h00);
    check("midbyte_rst_byte", 32'(rx_byte), 32'h00);
    check("midbyte_rst_core", 32'(dut.u_core.state_q), 32'(R_IDLE));
    check("midbyte_rst_parser", 32'(dut.pstate_q), 32'(S_SYNC));
    rst_n = 1'b1;
    wait_clks(2 * BIT_CLKS);
    snap();
    send_frame(8'hA5, 8'h01, 8'hC3, 8'hC2);
    wait_clks(BIT_CLKS);
    check("post_rst_ok", 32'(n_ok - o0), 32'd1);
    check("post_rst_led", 32'(led_export), 32'hC3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_led_frame_rx.md
Name: uart_led_frame_rx

Overview:
- Receive side of the WiFi-module serial link, sitting between the RS232 RXD GPIO pin and the LED bank.
- Deserialises 8N1 UART bytes, then parses 4-byte command frames sent by the WiFi module carrying audio level or raw LED data.
- Drives the 8-bit user LED output.
- Replaces the processor-based receive path with pure RTL, so the LED display does not depend on software.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate. Oversample divider is OVS_DIV = CLK_HZ/(BAUD*16), integer truncated (27 at defaults).
- TIMEOUT_BITS, 32, maximum inter-byte gap in bit times (16 ticks per bit) before the parser resynchronises.

Ports:
- clk_clk  in  1  system clock, single domain.
- reset_reset_n  in  1  asynchronous, active-low reset.
- rs232_rxd  in  1  asynchronous serial input; idles high.
- led_export  out  8  LED drive value.
- rx_byte  out  8  last received byte.
- rx_valid  out  1  one-cycle pulse when rx_byte updates.
- rx_framing_err  out  1  one-cycle pulse when the stop bit is sampled low.
- frame_ok  out  1  one-cycle pulse when a frame is accepted and led_export is updated.
- frame_err  out  1  one-cycle pulse on checksum error, unknown command or timeout.

Behaviour:
- Reset (async assert, sync deassert in the bench):
  - led_export=0x00, rx_byte=0x00, all pulses 0.
  - Parser in S_SYNC, receiver in R_IDLE.
  - Synchroniser flops reset to 1.
- RXD path: 2-flop synchroniser. The UART core sees only the synchronised line.
- Tick generator: counter 0..OVS_DIV-1. Emits a tick on wrap. Free-running.
- Receiver FSM, in the uart_rx_core sub-module:
  - R_IDLE: a low level seen on a tick goes to R_START and clears the tick counter.
  - R_START: after 8 ticks (mid start bit), sample the line. Low goes to R_DATA. High is a glitch: return to R_IDLE, no pulse.
  - R_DATA: sample every 16 ticks, LSB first, 8 bits.
  - R_STOP: sample at 16 ticks.
    - High: rx_byte loaded and rx_valid pulses on the same clock.
    - Low: rx_framing_err pulses, the byte is discarded, go to R_WAIT.
  - R_WAIT: stay until the line is high on a tick, then go to R_IDLE.
  - Latency: rx_valid asserts within 1 clock of the mid-stop-bit sample.
- Frame format: SYNC=0xA5, CMD, DATA, CHK, where CHK = CMD ^ DATA.
- Parser FSM, advancing only on rx_valid:
  - S_SYNC: 0xA5 goes to S_CMD. Any other byte is ignored silently.
  - S_CMD: latch CMD, go to S_DATA. A 0xA5 byte here is treated as CMD; no resync.
  - S_DATA: latch DATA, go to S_CHK.
  - S_CHK:
    - CHK mismatch: frame_err pulses.
    - CMD unknown: frame_err pulses.
    - Otherwise apply the frame and pulse frame_ok on the same clock that led_export updates, one clock after rx_valid.
    - Always return to S_SYNC.
- Commands:
  - 0x01 RAW: led_export = DATA.
  - 0x02 LEVEL: led_export = thermometer of min(DATA,8), i.e. (1<<n)-1. Examples: 0 -> 0x00, 3 -> 0x07, 8 and above -> 0xFF.
- Timeout: gap counter in ticks.
  - Cleared on rx_valid; counts only while the parser is not in S_SYNC.
  - Reaching TIMEOUT_BITS*16 ticks: frame_err pulses, parser goes to S_SYNC.
- Framing errors: an rx_framing_err while the parser is mid-frame also forces S_SYNC, with frame_err pulsing on the same cycle.
- A failed frame leaves led_export unchanged.
- Simultaneous timeout and rx_valid on one cycle: rx_valid wins, the byte is processed and the counter clears.
- Reset mid-byte or mid-frame: all state is discarded immediately; the next valid frame is accepted normally.
- Back-to-back frames with zero idle between stop and start bit must be accepted.

Decomposition:
- Shared package uart_led_pkg holds:
  - SYNC_BYTE=8'hA5, CMD_RAW=8'h01, CMD_LEVEL=8'h02.
  - Receiver state enum and parser state enum.
  - Function level_to_bar(8-bit) returning 8-bit.
- One sub-module, uart_rx_core: tick generator, synchroniser and receiver FSM, outputting rx_byte, rx_valid and rx_framing_err.
- The top of this block holds the parser, timeout counter and LED register.

Test Plan:
- Send A5 01 3C 3D at 115200 baud -> four rx_valid pulses, then frame_ok; led_export=0x3C.
- Send A5 02 05 07 -> led_export=0x1F. Then A5 02 20 22 -> led_export=0xFF.
- Send A5 01 3C 00 (bad CHK) -> frame_err, led_export unchanged. Then send a valid frame -> accepted.
- Byte 0x55 with stop bit held low -> rx_framing_err. Parser mid-frame -> frame_err and resync. The next A5 01 81 80 gives led_export=0x81.
- Send A5 01, then idle for 40 bit times -> frame_err at 32 bit times (+/-1 tick). Then a full frame -> accepted.
- 0.3-bit low glitch on idle line -> no rx_valid, no errors. Assert reset_reset_n=0 mid-byte -> led_export=0x00 and the FSMs return to idle.
